imem_loader: RTL and testbench

- Writer side of the instruction memory: receives a byte stream from a host/debug link and assembles it into 32-bit words.
- Issues single-cycle word writes (byte address, write enable, data) into the 256-word instruction memory.
- Holds the CPU core stalled while loading, then signals completion and an XOR checksum.
- Sits between the host byte interface and the instruction memory write port.

---
 rtl/imem_loader.sv | 106 ++++++++++
 tb/tb_imem_loader.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Instruction memory loader: assembles a little-endian host byte stream into 32-bit words,
// writes them sequentially from address 0, and reports completion with an XOR checksum.
module imem_loader #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned LEN_W = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] load_len,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             byte_ready,
  output logic             we,
  output logic [31:0]      w_addr,
  output logic [31:0]      w_data,
  output logic             busy,
  output logic             done,
  output logic [31:0]      checksum
);

  typedef enum logic [1:0] {StIdle, StLoad, StWrite, StDone} state_e;

  state_e           state;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] wcnt;
  logic [1:0]       bcnt;
  logic [23:0]      asm_word;

  logic [LEN_W-1:0] len_clamped;
  logic [LEN_W-1:0] wcnt_inc;

  assign len_clamped = (load_len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : load_len;
  assign wcnt_inc    = wcnt + LEN_W'(1);

  // Outputs are registered alongside the state so they always reflect the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= StIdle;
      len        <= '0;
      wcnt       <= '0;
      bcnt       <= '0;
      asm_word   <= '0;
      byte_ready <= 1'b0;
      we         <= 1'b0;
      w_addr     <= '0;
      w_data     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      checksum   <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (start) begin
            len      <= len_clamped;
            checksum <= '0;
            wcnt     <= '0;
            bcnt     <= '0;
            w_addr   <= '0;
            busy     <= 1'b1;
            if (len_clamped == '0) begin
              state <= StDone;
              done  <= 1'b1;
            end else begin
              state      <= StLoad;
              byte_ready <= 1'b1;
            end
          end
        end
        StLoad: begin
          if (byte_valid && byte_ready) begin
            bcnt <= bcnt + 2'd1;
            if (bcnt == 2'd3) begin
              w_data     <= {byte_data, asm_word};
              w_addr     <= 32'({wcnt, 2'b00});
              we         <= 1'b1;
              byte_ready <= 1'b0;
              state      <= StWrite;
            end else begin
              asm_word[8*bcnt +: 8] <= byte_data;
            end
          end
        end
        StWrite: begin
          we       <= 1'b0;
          checksum <= checksum ^ w_data;
          wcnt     <= wcnt_inc;
          if (wcnt_inc == len) begin
            state <= StDone;
            done  <= 1'b1;
          end else begin
            state      <= StLoad;
            byte_ready <= 1'b1;
          end
        end
        StDone: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: byte streaming, write addresses/data, checksum, clamp and reset.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [8:0]  load_len;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        we;
  logic [31:0] w_addr;
  logic [31:0] w_data;
  logic        busy;
  logic        done;
  logic [31:0] checksum;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];

  imem_loader #(
    .DEPTH(256),
    .LEN_W(9)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .load_len  (load_len),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .byte_ready(byte_ready),
    .we        (we),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .busy      (busy),
    .done      (done),
    .checksum  (checksum)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Write monitor; byte_ready must be low whenever a write is issued.
  always @(negedge clk) begin
    if (rst_n && we) begin
      wa_q.push_back(w_addr);
      wd_q.push_back(w_data);
      check_eq("byte_ready during we", {31'd0, byte_ready}, 32'd0);
    end
  end

  task automatic do_start(input int len);
    @(negedge clk);
    start    = 1'b1;
    load_len = 9'(len);
    @(negedge clk);
    start    = 1'b0;
  endtask

  // Present one byte and return at the negedge after the edge that accepted it.
  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int gap;
    int t;
    gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    for (int i = 0; i < gap; i++) begin
      byte_valid = 1'b0;
      @(negedge clk);
    end
    byte_valid = 1'b1;
    byte_data  = b;
    t = 0;
    while (!byte_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!byte_ready) check_eq("byte_ready timeout", {31'd0, byte_ready}, 32'd1);
    @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w, input int max_gap);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], max_gap);
  endtask

  // Called right after the final byte: done must appear exactly one negedge later.
  task automatic check_done_timing(input string tag);
    check_eq({tag, " done early"}, {31'd0, done}, 32'd0);
    @(negedge clk);
    check_eq({tag, " done pulse"}, {31'd0, done}, 32'd1);
  endtask

  task automatic check_writes(input string tag, input logic [31:0] exp_d[$]);
    check_eq({tag, " write count"}, 32'(wd_q.size()), 32'(exp_d.size()));
    for (int i = 0; i < exp_d.size() && i < wd_q.size(); i++) begin
      check_eq($sformatf("%s addr[%0d]", tag, i), wa_q[i], 32'(i * 4));
      check_eq($sformatf("%s data[%0d]", tag, i), wd_q[i], exp_d[i]);
    end
  endtask

  task automatic clear_log();
    repeat (2) @(negedge clk);
    wa_q.delete();
    wd_q.delete();
  endtask

  logic [31:0] exp_d[$];
  logic [31:0] w0, w1, w2, x, wv;

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    load_len   = '0;
    byte_valid = 1'b0;
    byte_data  = '0;
    w0 = 32'h00A00093;
    w1 = 32'h00108113;
    w2 = 32'hFFDFF06F;

    // Reset state
    repeat (2) @(negedge clk);
    check_eq("rst byte_ready", {31'd0, byte_ready}, 32'd0);
    check_eq("rst we",         {31'd0, we},         32'd0);
    check_eq("rst w_addr",     w_addr,              32'd0);
    check_eq("rst w_data",     w_data,              32'd0);
    check_eq("rst busy",       {31'd0, busy},       32'd0);
    check_eq("rst done",       {31'd0, done},       32'd0);
    check_eq("rst checksum",   checksum,            32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single word
    do_start(1);
    check_eq("t1 busy", {31'd0, busy}, 32'd1);
    send_word(32'h00000013, 0);
    byte_valid = 1'b0;
    check_done_timing("t1");
    check_eq("t1 checksum", checksum, 32'h00000013);
    @(negedge clk);
    check_eq("t1 busy after", {31'd0, busy}, 32'd0);
    exp_d = '{32'h00000013};
    check_writes("t1", exp_d);
    clear_log();

    // Three words, byte_valid held high throughout
    do_start(3);
    send_word(w0, 0);
    send_word(w1, 0);
    send_word(w2, 0);
    check_done_timing("t2");
    check_eq("t2 checksum", checksum, w0 ^ w1 ^ w2);
    byte_valid = 1'b0;
    exp_d = '{w0, w1, w2};
    check_writes("t2", exp_d);
    clear_log();

    // Two words with random host gaps
    do_start(2);
    send_word(w0, 3);
    send_word(w1, 3);
    byte_valid = 1'b0;
    check_done_timing("t3");
    check_eq("t3 checksum", checksum, w0 ^ w1);
    exp_d = '{w0, w1};
    check_writes("t3", exp_d);
    clear_log();

    // Zero-length load
    do_start(0);
    check_eq("t4 done", {31'd0, done}, 32'd1);
    check_eq("t4 checksum", checksum, 32'd0);
    @(negedge clk);
    check_eq("t4 done after", {31'd0, done}, 32'd0);
    check_eq("t4 busy after", {31'd0, busy}, 32'd0);
    exp_d = '{};
    check_writes("t4", exp_d);
    clear_log();

    // Oversized length clamps to 256 words
    do_start(300);
    x = '0;
    exp_d = '{};
    for (int i = 0; i < 256; i++) begin
      wv = (32'(i) * 32'h01010101) ^ 32'h5A3C0000;
      x ^= wv;
      exp_d.push_back(wv);
      send_word(wv, 0);
    end
    check_done_timing("t5");
    check_eq("t5 checksum", checksum, x);
    repeat (10) begin
      @(negedge clk);
      check_eq("t5 byte_ready after", {31'd0, byte_ready}, 32'd0);
    end
    check_eq("t5 w_addr hold", w_addr, 32'h000003FC);
    byte_valid = 1'b0;
    check_writes("t5", exp_d);
    check_eq("t5 last addr", wa_q[wa_q.size()-1], 32'h000003FC);
    clear_log();

    // Reset in the middle of a word
    do_start(1);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    byte_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_eq("t6 rst busy",       {31'd0, busy},       32'd0);
    check_eq("t6 rst byte_ready", {31'd0, byte_ready}, 32'd0);
    check_eq("t6 rst we",         {31'd0, we},         32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_start(1);
    send_word(32'hDEADBEEF, 0);
    byte_valid = 1'b0;
    check_done_timing("t6");
    check_eq("t6 checksum", checksum, 32'hDEADBEEF);
    exp_d = '{32'hDEADBEEF};
    repeat (2) @(negedge clk);
    check_writes("t6", exp_d);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
